// File: rtl/mem_req_pkg.sv
// Shared types for the memory request master.
// Holds the FSM state encoding, command bundle and default widths.
package mem_req_pkg;

   localparam int MEM_ADDR_W = 4;
   localparam int MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } mem_req_state_e;

   typedef struct packed {
      logic                  rnw;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/req_wait_timer.sv
// Saturating wait counter for the request phase.
// expired_o flags that the count has reached TIMEOUT.
module req_wait_timer #(
   parameter int TIMEOUT = 31
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] count;

   assign expired_o = (count == LIMIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr_i) begin
         count <= '0;
      end else if (en_i && !expired_o) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_req_master.sv
// Single-outstanding request master for the 16x32 memory.
// Holds req until ready or timeout, then returns a response.
module mem_req_master
   import mem_req_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W,
   parameter int TIMEOUT = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_rnw_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              req_o,
   output logic              req_rnw_o,
   output logic [ADDR_W-1:0] req_addr_o,
   output logic [DATA_W-1:0] req_wdata_o,
   input  logic              req_ready_i,
   input  logic [DATA_W-1:0] req_rdata_i,
   output logic              busy_o
);

   mem_req_state_e state;
   logic           cmd_fire;
   logic           expired;

   assign cmd_ready_o = (state == IDLE);
   assign req_o       = (state == REQ);
   assign rsp_valid_o = (state == RSP);
   assign busy_o      = (state != IDLE);
   assign cmd_fire    = cmd_valid_i && cmd_ready_o;

   req_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (cmd_fire),
      .en_i      (req_o && !req_ready_i),
      .expired_o (expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         req_rnw_o   <= 1'b0;
         req_addr_o  <= '0;
         req_wdata_o <= '0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  req_rnw_o   <= cmd_rnw_i;
                  req_addr_o  <= cmd_addr_i;
                  req_wdata_o <= cmd_wdata_i;
                  state       <= REQ;
               end
            end
            REQ: begin
               // A ready in the final wait cycle still counts as success.
               if (req_ready_i) begin
                  rsp_rdata_o <= req_rnw_o ? req_rdata_i : '0;
                  rsp_err_o   <= 1'b0;
                  state       <= RSP;
               end else if (expired) begin
                  rsp_rdata_o <= '0;
                  rsp_err_o   <= 1'b1;
                  state       <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master.
// Vector table for single transactions plus hand-written corner sequences.
module tb_mem_req_master;
   import mem_req_pkg::*;

   localparam int TO = 31;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_rnw_i = 1'b0;
   logic [3:0]  cmd_addr_i = '0;
   logic [31:0] cmd_wdata_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        req_o;
   logic        req_rnw_o;
   logic [3:0]  req_addr_o;
   logic [31:0] req_wdata_o;
   logic        req_ready_i = 1'b0;
   logic [31:0] req_rdata_i;
   logic        busy_o;

   logic        mem_en = 1'b0;
   logic [31:0] rdata_drv = '0;
   logic [31:0] mem [16];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_req_master #(
      .ADDR_W  (4),
      .DATA_W  (32),
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_rnw_i   (cmd_rnw_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_wdata_i (cmd_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .req_o       (req_o),
      .req_rnw_o   (req_rnw_o),
      .req_addr_o  (req_addr_o),
      .req_wdata_o (req_wdata_o),
      .req_ready_i (req_ready_i),
      .req_rdata_i (req_rdata_i),
      .busy_o      (busy_o)
   );

   // Behavioural 16x32 memory, used only when mem_en is set.
   assign req_rdata_i = mem_en ? mem[req_addr_o] : rdata_drv;

   always @(posedge clk) begin
      if (mem_en && req_o && req_ready_i && !req_rnw_o)
         mem[req_addr_o] <= req_wdata_o;
   end

   typedef struct {
      mem_cmd_t    cmd;
      int          wait_n;
      logic [31:0] rdata;
      int          hold;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_req;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int nreq;
      int guard;
      logic [31:0] rd;
      logic        er;
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_rnw_i   = v.cmd.rnw;
      cmd_addr_i  = v.cmd.addr;
      cmd_wdata_i = v.cmd.wdata;
      rdata_drv   = v.rdata;
      rsp_ready_i = 1'b0;
      req_ready_i = 1'b0;
      @(negedge clk);
      cmd_valid_i = 1'b0;
      nreq  = 0;
      guard = 0;
      while (!rsp_valid_o && guard < 100) begin
         if (req_o) begin
            if (nreq == 0) begin
               chk("req_rnw", 32'(req_rnw_o), 32'(v.cmd.rnw));
               chk("req_addr", 32'(req_addr_o), 32'(v.cmd.addr));
               chk("req_wdata", req_wdata_o, v.cmd.wdata);
            end
            req_ready_i = (nreq == v.wait_n);
            nreq++;
         end
         @(negedge clk);
         req_ready_i = 1'b0;
         guard++;
      end
      chk("rsp_arrived", 32'(rsp_valid_o), 32'd1);
      chk("req_cycles", 32'(nreq), 32'(v.exp_req));
      chk("rsp_rdata", rsp_rdata_o, v.exp_rdata);
      chk("rsp_err", 32'(rsp_err_o), 32'(v.exp_err));
      chk("req_low_rsp", 32'(req_o), 32'd0);
      chk("cmd_rdy_rsp", 32'(cmd_ready_o), 32'd0);
      rd = rsp_rdata_o;
      er = rsp_err_o;
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid_o), 32'd1);
         chk("hold_rdata", rsp_rdata_o, rd);
         chk("hold_err", 32'(rsp_err_o), 32'(er));
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      chk("rsp_done", 32'(rsp_valid_o), 32'd0);
      chk("idle_rdy", 32'(cmd_ready_o), 32'd1);
   endtask

   initial begin
      int cnt;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      //      cmd{rnw,addr,wdata}       wait rdata         hold exp_rdata     err req
      vecs[0] = '{'{1'b0, 4'd3, 32'hDEADBEEF}, 0, 32'hAAAA5555, 0, 32'h0, 1'b0, 1};
      vecs[1] = '{'{1'b1, 4'd3, 32'h0}, 5, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 6};
      vecs[2] = '{'{1'b1, 4'd7, 32'h0}, 99, 32'h11112222, 0, 32'h0, 1'b1, TO + 1};
      vecs[3] = '{'{1'b1, 4'd7, 32'h0}, TO, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b0, TO + 1};
      vecs[4] = '{'{1'b1, 4'd1, 32'h0}, 2, 32'h0BADC0DE, 4, 32'h0BADC0DE, 1'b0, 3};
      vecs[5] = '{'{1'b0, 4'd15, 32'h5A5A5A5A}, 99, 32'h0, 2, 32'h0, 1'b1, TO + 1};

      #1;
      chk("rst_req", 32'(req_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_cmd_rdy", 32'(cmd_ready_o), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_rdata", rsp_rdata_o, 32'd0);
      chk("rst_err", 32'(rsp_err_o), 32'd0);
      chk("rst_addr", 32'(req_addr_o), 32'd0);
      chk("rst_wdata", req_wdata_o, 32'd0);
      chk("rst_rnw", 32'(req_rnw_o), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Command held valid while the response is back-pressured.
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_rnw_i   = 1'b1;
      cmd_addr_i  = 4'd2;
      rdata_drv   = 32'h13579BDF;
      @(negedge clk);
      cmd_addr_i  = 4'd5;
      req_ready_i = 1'b1;
      @(negedge clk);
      req_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_valid", 32'(rsp_valid_o), 32'd1);
         chk("bp_rdata", rsp_rdata_o, 32'h13579BDF);
         chk("bp_cmd_rdy", 32'(cmd_ready_o), 32'd0);
         chk("bp_req", 32'(req_o), 32'd0);
         @(negedge clk);
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      chk("bp_idle_rdy", 32'(cmd_ready_o), 32'd1);
      chk("bp_idle_valid", 32'(rsp_valid_o), 32'd0);
      @(negedge clk);
      cmd_valid_i = 1'b0;
      chk("bp_next_req", 32'(req_o), 32'd1);
      chk("bp_next_addr", 32'(req_addr_o), 32'd5);
      req_ready_i = 1'b1;
      @(negedge clk);
      req_ready_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;

      // Reset asserted in the third REQ cycle.
      cmd_valid_i = 1'b1;
      cmd_rnw_i   = 1'b0;
      cmd_addr_i  = 4'd4;
      @(negedge clk);
      cmd_valid_i = 1'b0;
      cnt = 0;
      while (req_o && cnt < 2) begin
         @(negedge clk);
         cnt++;
      end
      chk("rst_mid_pre", 32'(req_o), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("rst_mid_req", 32'(req_o), 32'd0);
      chk("rst_mid_busy", 32'(busy_o), 32'd0);
      chk("rst_mid_valid", 32'(rsp_valid_o), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_rdy", 32'(cmd_ready_o), 32'd1);
      chk("rst_mid_valid2", 32'(rsp_valid_o), 32'd0);
      run_vec(vecs[0]);

      // Write then read back through the memory model.
      mem_en = 1'b1;
      run_vec('{'{1'b0, 4'd9, 32'h12345678}, 0, 32'h0, 0, 32'h0, 1'b0, 1});
      run_vec('{'{1'b1, 4'd9, 32'h0}, 0, 32'h0, 0, 32'h12345678, 1'b0, 1});
      mem_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_req_master.md
# mem_req_master

Upstream request master for the 16x32 memory interface. Accepts one command at a time on a valid/ready command port and drives the memory's level-sensitive `req`/`rnw`/`addr`/`wdata` bundle. Holds the request until the memory's `ready` rises, or until a wait timeout expires. Returns read data, or a write acknowledge, on a valid/ready response port.

## Interface
- `ADDR_W`, 4: memory address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 31: maximum cycles `req_o` may stay high without `req_ready_i` before the transaction aborts. Legal range ≥ 1.

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid_i` in 1: command offered.
- `cmd_ready_o` out 1: command accepted when `cmd_valid_i & cmd_ready_o`.
- `cmd_rnw_i` in 1: 1 = read, 0 = write.
- `cmd_addr_i` in ADDR_W: command address.
- `cmd_wdata_i` in DATA_W: write data; ignored for reads.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: response consumed when `rsp_valid_o & rsp_ready_i`.
- `rsp_rdata_o` out DATA_W: read data; 0 for writes and on error.
- `rsp_err_o` out 1: transaction timed out.
- `req_o` out 1: memory request, level.
- `req_rnw_o` out 1: memory read/not-write.
- `req_addr_o` out ADDR_W: memory address.
- `req_wdata_o` out DATA_W: memory write data.
- `req_ready_i` in 1: memory ready; the transfer completes in any cycle with `req_o & req_ready_i`.
- `req_rdata_i` in DATA_W: memory read data, valid combinationally in the completing cycle.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - `cmd_ready_o` = 1.
  - On handshake, register rnw, addr and wdata into the `req_*` registers, clear the wait counter, go to REQ.
- REQ:
  - `req_o` = 1; `req_*` registers are stable.
  - If `req_ready_i` = 1: capture `req_rdata_i` into `rsp_rdata_o` for a read, or 0 for a write. Set `rsp_err_o` = 0. Go to RSP.
  - Else if wait counter == TIMEOUT: `rsp_rdata_o` = 0, `rsp_err_o` = 1, go to RSP.
  - Else: increment the wait counter.
- RSP:
  - `rsp_valid_o` = 1; `req_o` = 0.
  - On `rsp_ready_i`, go to IDLE.
  - RSP lasts ≥1 cycle, which guarantees `req_o` is low for ≥1 cycle between transactions. The memory needs this to see a fresh rising edge of `req`.
- Response fields stay stable while `rsp_valid_o & ~rsp_ready_i`.
- `cmd_ready_o` = 0 outside IDLE. No command buffering. Peak throughput is one command per 3 cycles.
- Wait counter width is $clog2(TIMEOUT+1). It never wraps: it stops at TIMEOUT.
- Simultaneous `req_ready_i` and counter == TIMEOUT: success wins, `rsp_err_o` = 0.
- A write that times out may or may not have been performed by the memory. The error flag reports only that the master gave up.

## Timing
- Reset (`reset` low), asynchronous and immediate:
  - state = IDLE, wait counter = 0.
  - `req_o` = 0, `req_rnw_o` = 0, `req_addr_o` = 0, `req_wdata_o` = 0.
  - `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0.
  - `busy_o` = 0, `cmd_ready_o` = 1.
- Reset mid-REQ drops `req_o` in the same cycle. Any in-flight response is discarded.
- `req_o`, `rsp_valid_o`, `cmd_ready_o` and `busy_o` decode directly from the state register; no combinational input-to-output paths.
- Latency, command accept to `rsp_valid_o`: 1 + N + 1 cycles, where N is the number of REQ cycles with `req_ready_i` low (0..TIMEOUT).
- Minimum latency is 2 cycles: accept at edge k, `req_o` high in cycle k+1 with ready, `rsp_valid_o` high in cycle k+2.
- Timeout: `req_o` is high for exactly TIMEOUT+1 cycles, then `rsp_valid_o` is asserted with `rsp_err_o` = 1.

## Structure
- Package `mem_req_pkg` holds:
  - `mem_req_state_e` (IDLE/REQ/RSP enum).
  - `mem_cmd_t` struct {rnw, addr, wdata}.
  - Default widths for ADDR_W and DATA_W.
- One sub-module, `req_wait_timer`: clear, enable, saturating count, `expired_o` = (count == TIMEOUT); parameter TIMEOUT.
- Everything else, including the FSM and the capture registers, lives in `mem_req_master`.

## Test plan
1. Write addr 3, data 0xDEADBEEF; `req_ready_i` held high → `req_o` high 1 cycle with addr 3 / wdata 0xDEADBEEF / rnw 0. Next cycle `rsp_valid_o` = 1, `rsp_err_o` = 0, `rsp_rdata_o` = 0.
2. Read addr 3; `req_ready_i` low 5 cycles, then high with `req_rdata_i` = 0xDEADBEEF → `req_o` high 6 cycles, `rsp_rdata_o` = 0xDEADBEEF, `rsp_err_o` = 0.
3. TIMEOUT = 31, read with `req_ready_i` tied low → `req_o` high 32 cycles, then `rsp_valid_o` = 1, `rsp_err_o` = 1, `rsp_rdata_o` = 0. Repeat with ready rising in exactly the 32nd cycle → `rsp_err_o` = 0.
4. `rsp_ready_i` held low 4 cycles while `cmd_valid_i` = 1 → response fields stable, `cmd_ready_o` = 0, `req_o` = 0. Command accepted the cycle after `rsp_ready_i` rises.
5. Assert `reset` low in the 3rd REQ cycle → `req_o`, `busy_o` and `rsp_valid_o` go to 0 immediately. After release, `cmd_ready_o` = 1 and the next command runs normally.
6. Connected to the memory interface: write 0x12345678 to addr 9, then read addr 9 → `rsp_rdata_o` = 0x12345678. `req_o` is low ≥1 cycle between the two requests, and no timeout occurs with TIMEOUT ≥ 16.
